// File: rtl/imem_loader.sv
// Boot loader: packs a length-prefixed byte stream into big-endian 32-bit words for imem.
// Optional trailing XOR checksum byte is enabled by defining LOADER_CSUM_EN.
module imem_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  core_reset,
  output logic                  done,
  output logic                  error
);

  localparam logic [31:0] CAPACITY = 32'd1 << ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
`ifdef LOADER_CSUM_EN
    S_CSUM,
`endif
    S_FLUSH,
    S_DONE,
    S_ERR
  } state_t;

  state_t                state_reg, state_next;
  logic [15:0]           len_reg, len_next;
  logic [23:0]           asm_reg, asm_next;
  logic [1:0]            idx_reg, idx_next;
  logic [ADDR_WIDTH:0]   cnt_reg, cnt_next;
  logic                  we_reg, we_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [31:0]           wdata_reg, wdata_next;
`ifdef LOADER_CSUM_EN
  logic [7:0]            csum_reg, csum_next;
`endif

  logic        accept;
  logic [15:0] n_in;
  logic        cnt_last;

  assign accept   = in_valid && in_ready;
  assign n_in     = {len_reg[15:8], in_data};
  assign cnt_last = (32'(cnt_reg) + 32'd1) == 32'(len_reg);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_LEN_HI;
      len_reg   <= '0;
      asm_reg   <= '0;
      idx_reg   <= '0;
      cnt_reg   <= '0;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
`ifdef LOADER_CSUM_EN
      csum_reg  <= '0;
`endif
    end else begin
      state_reg <= state_next;
      len_reg   <= len_next;
      asm_reg   <= asm_next;
      idx_reg   <= idx_next;
      cnt_reg   <= cnt_next;
      we_reg    <= we_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
`ifdef LOADER_CSUM_EN
      csum_reg  <= csum_next;
`endif
    end
  end

  always_comb begin
    state_next = state_reg;
    len_next   = len_reg;
    asm_next   = asm_reg;
    idx_next   = idx_reg;
    cnt_next   = cnt_reg;
    we_next    = 1'b0;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
`ifdef LOADER_CSUM_EN
    csum_next  = csum_reg;
`endif
    case (state_reg)
      S_LEN_HI: if (accept) begin
        len_next   = {in_data, 8'h00};
        state_next = S_LEN_LO;
      end
      S_LEN_LO: if (accept) begin
        len_next = n_in;
        if (32'(n_in) > CAPACITY) begin
          state_next = S_ERR;
        end else if (n_in == 16'd0) begin
`ifdef LOADER_CSUM_EN
          state_next = S_CSUM;
`else
          state_next = S_FLUSH;
`endif
        end else begin
          state_next = S_DATA;
        end
      end
      S_DATA: if (accept) begin
        asm_next = {asm_reg[15:0], in_data};
        idx_next = idx_reg + 2'd1;
`ifdef LOADER_CSUM_EN
        csum_next = csum_reg ^ in_data;
`endif
        // Fourth byte completes the word; the counter doubles as the write address.
        if (idx_reg == 2'd3) begin
          we_next    = 1'b1;
          addr_next  = cnt_reg[ADDR_WIDTH-1:0];
          wdata_next = {asm_reg, in_data};
          cnt_next   = cnt_reg + 1'b1;
          if (cnt_last) begin
`ifdef LOADER_CSUM_EN
            state_next = S_CSUM;
`else
            state_next = S_FLUSH;
`endif
          end
        end
      end
`ifdef LOADER_CSUM_EN
      S_CSUM: if (accept) begin
        state_next = (in_data == csum_reg) ? S_FLUSH : S_ERR;
      end
`endif
      S_FLUSH: state_next = S_DONE;
      S_DONE:  state_next = S_DONE;
      S_ERR:   state_next = S_ERR;
      default: state_next = S_ERR;
    endcase
  end

  always_comb begin
    in_ready   = 1'b0;
    core_reset = 1'b1;
    done       = 1'b0;
    error      = 1'b0;
    case (state_reg)
      S_LEN_HI, S_LEN_LO, S_DATA: in_ready = 1'b1;
`ifdef LOADER_CSUM_EN
      S_CSUM:  in_ready = 1'b1;
`endif
      S_DONE: begin
        core_reset = 1'b0;
        done       = 1'b1;
      end
      S_ERR:   error = 1'b1;
      default: in_ready = 1'b0;
    endcase
  end

  assign imem_we    = we_reg;
  assign imem_addr  = addr_reg;
  assign imem_wdata = wdata_reg;

endmodule
